// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the IF stage: reset level, bus widths, fetch FSM encoding.
package inst_fetch_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam int   InstAddrBus = 32;
  localparam int   InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [InstAddrBus-1:0] next_pc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding register that catches a fetched word while the output slot is stalled.
module fetch_skid_buf
  import inst_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [InstAddrBus-1:0] load_pc,
  input  logic [InstBus-1:0]     load_inst,
  input  logic                   drain,
  input  logic                   flush,
  output logic                   full,
  output logic [InstAddrBus-1:0] pc,
  output logic [InstBus-1:0]     inst
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      full <= 1'b0;
      pc   <= ZeroWord;
      inst <= ZeroWord;
    end else if (load) begin
      full <= 1'b1;
      pc   <= load_pc;
      inst <= load_inst;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: PC generation, req/ack fetch from instruction memory, valid-qualified output slot
// backed by a one-entry skid, with ID stall and EX/ID branch redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  output logic                   if_valid_o,
  output logic [1:0]             dbg_state_o
);

  fetch_state_e           state_q;
  logic [InstAddrBus-1:0] pc_q;
  logic [InstAddrBus-1:0] redir_q;
  logic                   slot_valid_q;
  logic [InstAddrBus-1:0] slot_pc_q;
  logic [InstBus-1:0]     slot_inst_q;

  logic                   skid_full;
  logic [InstAddrBus-1:0] skid_pc;
  logic [InstBus-1:0]     skid_inst;
  logic                   ack_taken;
  logic                   slot_open;
  logic                   skid_load;
  logic                   skid_drain;

  // Handshake: a transfer happens on any cycle with imem_req_o && imem_ack_i (ack may arrive in
  // the request cycle). Once raised, req and addr hold until that cycle; in RUN req only launches
  // with the skid empty, so an accepted word always has somewhere to go.
  assign imem_req_o  = (state_q == DROP) || ((state_q == RUN) && !skid_full);
  assign imem_addr_o = pc_q;
  assign ack_taken   = imem_req_o && imem_ack_i;
  assign slot_open   = !slot_valid_q || !stall_i;

  assign skid_load  = (state_q == RUN) && !branch_flag_i && ack_taken && !slot_open;
  assign skid_drain = (state_q == RUN) && !branch_flag_i && slot_open && skid_full;

  assign if_valid_o  = slot_valid_q;
  assign if_pc_o     = slot_pc_q;
  assign if_inst_o   = slot_inst_q;
  assign dbg_state_o = state_q;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .load_pc   (pc_q),
    .load_inst (imem_rdata_i),
    .drain     (skid_drain),
    .flush     (branch_flag_i),
    .full      (skid_full),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      redir_q      <= RESET_PC;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= ZeroWord;
      slot_inst_q  <= ZeroWord;
    end else if (branch_flag_i) begin
      slot_valid_q <= 1'b0;
      // An outstanding request cannot be withdrawn, so park the target until its ack returns.
      if (imem_req_o && !imem_ack_i) begin
        redir_q <= branch_target_i;
        state_q <= DROP;
      end else begin
        pc_q    <= branch_target_i;
        state_q <= RUN;
      end
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (ack_taken) pc_q <= next_pc(pc_q);
          if (slot_open) begin
            if (skid_full) begin
              slot_valid_q <= 1'b1;
              slot_pc_q    <= skid_pc;
              slot_inst_q  <= skid_inst;
            end else if (ack_taken) begin
              slot_valid_q <= 1'b1;
              slot_pc_q    <= pc_q;
              slot_inst_q  <= imem_rdata_i;
            end else begin
              slot_valid_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            pc_q    <= redir_q;
            state_q <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios, then random stall/branch/wait traffic against a
// program-order model of the presented instruction stream.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;
  logic [1:0]  dbg_state;

  logic        w_req, w_ack;
  logic [31:0] w_addr, w_rdata, w_pc, w_inst;
  logic        w_valid;
  logic [1:0]  w_state;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  int consumed = 0;
  bit mon_en = 1'b0;
  bit flush_chk = 1'b0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: ack once the request has been held for mem_wait cycles (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata = rom(imem_addr);
  assign w_ack      = w_req;
  assign w_rdata    = rom(w_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch_flag),
    .branch_target_i(branch_target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata), .if_pc_o(if_pc), .if_inst_o(if_inst),
    .if_valid_o(if_valid), .dbg_state_o(dbg_state)
  );

  inst_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(w_ack), .imem_rdata_i(w_rdata), .if_pc_o(w_pc), .if_inst_o(w_inst),
    .if_valid_o(w_valid), .dbg_state_o(w_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Program-order model: each consumed slot must be the next PC after the last branch target.
  task automatic monitor();
    if (flush_chk) begin
      check("flush_valid", 32'(if_valid), 32'd0);
      flush_chk = 1'b0;
    end
    if (pend && imem_req) check("addr_stable", imem_addr, pend_addr);
    pend      = imem_req && !imem_ack;
    pend_addr = imem_addr;
    if (branch_flag) begin
      exp_pc    = branch_target;
      flush_chk = 1'b1;
    end else if (if_valid && !stall) begin
      check("seq_pc", if_pc, exp_pc);
      check("seq_inst", if_inst, rom(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!if_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_pc"}, if_valid ? if_pc : 32'hDEAD_DEAD, exp);
    check({tag, "_inst"}, if_inst, rom(exp));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0; mem_wait = 0;
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(BOOT));
    check("rst_wrap_addr", w_addr, WRAP_PC);

    // Zero-wait ROM, no stall: one instruction per cycle, first two cycles after reset.
    rst = 1'b0;
    tick();
    check("boot_valid", 32'(if_valid), 32'd0);
    check("boot_req", 32'(imem_req), 32'd1);
    tick();
    check("zw_pc0", if_pc, 32'h0);
    check("zw_inst0", if_inst, rom(32'h0));
    check("wrap_pc0", w_pc, WRAP_PC);
    tick();
    check("zw_pc4", if_pc, 32'h4);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    tick();
    check("zw_pc8", if_pc, 32'h8);
    check("wrap_pc2", w_pc, 32'h0);
    check("wrap_inst2", w_inst, rom(32'h0));

    // Stall three cycles at PC 8: slot holds, skid catches C, request drops.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", if_pc, 32'h8);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("release_pc_c", if_pc, 32'hC);
    check("release_req", 32'(imem_req), 32'd1);
    tick();
    check("release_pc_10", if_pc, 32'h10);
    check("release_valid", 32'(if_valid), 32'd1);

    // Three-wait memory: address held while waiting, one valid per ack.
    mem_wait = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w3_valid", 32'(if_valid), 32'd0);
      check("w3_addr", imem_addr, 32'h14);
      check("w3_req", 32'(imem_req), 32'd1);
    end
    tick();
    check("w3_pc", if_valid ? if_pc : 32'hDEAD_DEAD, 32'h14);
    check("w3_inst", if_inst, rom(32'h14));
    tick();
    check("w3_single", 32'(if_valid), 32'd0);
    check("w3_next_addr", imem_addr, 32'h18);

    // Branch one cycle into a three-wait request: stale word dropped, resume at 0x100.
    branch_flag = 1'b1; branch_target = 32'h100;
    tick();
    branch_flag = 1'b0;
    check("drop_addr", imem_addr, 32'h18);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_valid", 32'(if_valid), 32'd0);
    check("drop_state", 32'(dbg_state), 32'(DROP));
    wait_valid("redir100", 32'h100);

    // Skid full under stall, then branch to 0x200: everything flushed.
    mem_wait = 0;
    stall = 1'b1;
    tick();
    check("skid_pc", if_pc, 32'h100);
    check("skid_req", 32'(imem_req), 32'd0);
    branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    branch_flag = 1'b0;
    check("flush200_valid", 32'(if_valid), 32'd0);
    check("flush200_addr", imem_addr, 32'h200);
    wait_valid("redir200", 32'h200);

    // Branch on the same cycle as an ack while stalled: the acked word is dropped.
    check("ack_branch_req", 32'(imem_req), 32'd1);
    branch_flag = 1'b1; branch_target = 32'h300;
    tick();
    branch_flag = 1'b0;
    check("flush300_valid", 32'(if_valid), 32'd0);
    check("flush300_addr", imem_addr, 32'h300);
    wait_valid("redir300", 32'h300);
    stall = 1'b0;

    // Reset in the middle of a wait: back to BOOT and the reset PC.
    mem_wait = 3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", 32'(if_valid), 32'd0);
    rst = 1'b0;
    wait_valid("midrst_reload", 32'h0);

    // Random traffic checked against the program-order model.
    exp_pc = 32'h0; pend = 1'b0; flush_chk = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_flag   = ($urandom_range(0, 24) == 0);
      branch_target = $urandom() & 32'hFFFF_FFFC;
      mem_wait      = $urandom_range(0, 3);
      tick();
    end
    branch_flag = 1'b0; stall = 1'b0;
    mon_en = 1'b0;
    check("progress", 32'(consumed >= 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
